r_i_cpu_mc: RTL and testbench
=============================

# r_i_cpu_mc

Parametrised multi-cycle R/I-type CPU core: fetches 32-bit MIPS-format instructions over a wait-state-capable instruction-memory handshake, executes the R-type and I-type ALU subset through a FETCH/DECODE/EXEC/WB state machine, and exposes the last result and flags for the bench and the top-level debug path. It adds to the single-cycle R/I CPU:
- configurable data and PC widths;
- an overflow-trap mode;
- illegal-opcode halt;
- an explicit retire strobe.

## Interface
- `DW`, 32: datapath width, legal range 16..64.
- `IAW`, 8: instruction word-address width (PC width).
- `RESET_PC`, 0: PC value after reset.
- `OF_TRAP`, 0: when 1, signed-overflowing add/sub/addi suppress register write-back.
- `clka`  in  1  sole clock, rising edge.
- `rsta`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  IAW  fetch word address (= PC).
- `imem_ack`  in  1  fetch complete; `imem_data` valid in the same cycle.
- `imem_data`  in  32  instruction word.
- `douta`  out  DW  result of last retired instruction.
- `ofa`  out  1  signed overflow of last retired instruction.
- `zfa`  out  1  result == 0 for last retired instruction.
- `retire`  out  1  one-cycle pulse in the WB cycle.
- `halted`  out  1  sticky; set by an illegal instruction.

## Operation
**Register file**
- 32 × DW; $0 reads 0, writes to $0 discarded.
- Reset clears all registers.

**Supported encodings** (op[31:26], funct[5:0])
- R-type (op 000000), by funct:
  - add 100000, sub 100010
  - and 100100, or 100101, xor 100110, nor 100111
  - slt 101010 (signed)
  - sll 000000, srl 000010 (amount = shamt[10:6]; amount ≥ DW yields 0)
- R-type destination is rd.
- I-type:
  - addi 001000, slti 001010 (imm sign-extended to DW)
  - andi 001100, ori 001101, xori 001110 (imm zero-extended)
  - lui 001111 = imm<<16, truncated to DW (0 when DW=16)
- I-type destination is rt.
- Any other op/funct is illegal.

**State machine** (states FETCH, DECODE, EXEC, WB, HALT)
- FETCH:
  - Drive `imem_req`=1 and `imem_addr`=PC.
  - Both are held stable until `imem_ack` is sampled high; IR is latched on that edge, then go to DECODE.
- DECODE:
  - Read rs/rt and extend imm.
  - Illegal instruction → HALT.
- EXEC:
  - ALU result and overflow are registered.
  - Overflow is defined only for add/sub/addi (signed, DW-bit); it is 0 for all other ops.
- WB:
  - Write the destination unless (`OF_TRAP`=1 and overflow).
  - Update `douta`/`ofa`/`zfa`; pulse `retire`.
  - PC ← PC+1, wrapping modulo 2^IAW; then go to FETCH.
- HALT:
  - `halted`=1, `imem_req`=0.
  - `douta`/`ofa`/`zfa` frozen.
  - Left only by `rsta`.

**Flags**
- `douta` and `zfa` reflect the ALU result even when write-back is trapped.
- `ofa`=1 in that case.

## Timing
**Reset values**
- `imem_req`=0, `imem_addr`=RESET_PC.
- `douta`=0, `ofa`=0, `zfa`=0, `retire`=0, `halted`=0.
- State FETCH, PC=RESET_PC.

**Reset behaviour**
- All outputs take their reset values immediately on `rsta` rising, asynchronously, from any state, including mid-fetch and HALT.
- The first `imem_req` is asserted in the first cycle after `rsta` falls.

**Latency**
- Zero-wait memory (ack in the first request cycle): exactly 4 cycles per instruction, so `retire` every 4th cycle.
- Each wait cycle adds one.

**Handshake rules**
- `imem_ack` while `imem_req`=0 is ignored.
- `imem_req` drops in the cycle after the ack edge.
- One request per instruction; no speculative fetch.

**Other boundary behaviour**
- A register written in WB is visible to the next instruction's DECODE; there are no hazards.
- PC at 2^IAW−1 wraps to 0.

## Structure
**Shared package** `r_i_cpu_pkg`:
- opcode and funct constants;
- ALU-op enum;
- state enum;
- instruction-field slice helpers (rs/rt/rd/shamt/imm positions).

**Sub-module** `r_i_alu`:
- combinational, parametrised by DW;
- inputs: a, b, alu-op, shamt;
- outputs: result, overflow.

The core holds the FSM, PC, IR, register file and output registers.

## Test plan
- Zero-wait program `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2` → `retire` on cycles 4/8/12; final `douta`=2, `zfa`=0, `ofa`=0.
- Overflow, run once with `OF_TRAP`=0 and once with `OF_TRAP`=1. Program: `lui $1,0x7FFF`; `ori $1,$1,0xFFFF`; `addi $2,$1,1`; then `add $3,$2,$0`.
  - `addi` step, both builds → `douta`=0x80000000, `ofa`=1.
  - `add $3,$2,$0`, `OF_TRAP`=1 → `douta`=0, `zfa`=1 ($2 unwritten).
  - `add $3,$2,$0`, `OF_TRAP`=0 → `douta`=0x80000000.
- `imem_ack` delayed 3 cycles → `imem_req`/`imem_addr` stable throughout, `retire` 3 cycles later than zero-wait, exactly one IR latch.
- Illegal word 0xFC000000 after `addi $1,$0,9` → `halted`=1 in cycle after DECODE, `imem_req` stays 0, `douta` stays 9 for 20 cycles.
- `rsta` pulse during EXEC → all outputs reset within the same cycle, next fetch address = `RESET_PC`, registers read 0.
- `addi $0,$0,7`; `add $1,$0,$0` → second retire `douta`=0, `zfa`=1; plus PC wrap with `IAW`=2 (5th fetch address 0).

Source files
------------

// File: rtl/r_i_cpu_pkg.sv
// Shared encodings, ALU operation set, FSM states and instruction-field
// helpers for the multi-cycle R/I-type core.
package r_i_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_HALT
    } state_t;

    function automatic logic [5:0] f_op(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [4:0] f_shamt(input logic [31:0] ir);
        return ir[10:6];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] ir);
        return ir[5:0];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] ir);
        return ir[15:0];
    endfunction

endpackage

// File: rtl/r_i_alu.sv
// Combinational ALU for the R/I-type core; overflow is meaningful only for
// signed add/sub and is forced low for every other operation.
module r_i_alu
    import r_i_cpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_t       alu_op,
    input  logic [4:0]    shamt,
    output logic [DW-1:0] result,
    output logic          overflow
);

    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic          big_shift;

    assign sum       = a + b;
    assign diff      = a - b;
    // Only reachable for DW < 32; the shift result is defined as zero there.
    assign big_shift = int'(shamt) >= DW;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result   = sum;
                overflow = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = DW'($signed(a) < $signed(b));
            ALU_SLL: result = big_shift ? '0 : (b << shamt);
            ALU_SRL: result = big_shift ? '0 : (b >> shamt);
            ALU_LUI: result = b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/r_i_cpu_mc.sv
// Multi-cycle R/I-type core: handshake fetch, decode, execute, write-back,
// with optional overflow trap and sticky halt on illegal instructions.
//
// state  | meaning
// FETCH  | imem_req held with imem_addr=PC until imem_ack; IR latched on ack
// DECODE | read rs/rt, extend imm, pick ALU op; illegal word goes to HALT
// EXEC   | ALU result/flags registered into douta/ofa/zfa, retire raised
// WB     | register write (unless trapped), PC+1, re-arm fetch request
// HALT   | outputs frozen, no requests; only rsta leaves
module r_i_cpu_mc
    import r_i_cpu_pkg::*;
#(
    parameter int             DW       = 32,
    parameter int             IAW      = 8,
    parameter logic [IAW-1:0] RESET_PC = '0,
    parameter int             OF_TRAP  = 0
) (
    input  logic           clka,
    input  logic           rsta,
    output logic           imem_req,
    output logic [IAW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [31:0]    imem_data,
    output logic [DW-1:0]  douta,
    output logic           ofa,
    output logic           zfa,
    output logic           retire,
    output logic           halted
);

    state_t         state;
    logic [IAW-1:0] pc;
    logic [31:0]    ir;
    logic [DW-1:0]  regs [32];
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
    alu_op_t        op_q;
    logic [4:0]     shamt_q;
    logic [4:0]     dest_q;

    logic [5:0]     opc;
    logic [5:0]     fn;
    logic [4:0]     rs;
    logic [4:0]     rt;
    logic [4:0]     rd;
    logic [15:0]    imm;
    logic [DW-1:0]  rs_val;
    logic [DW-1:0]  rt_val;
    logic [DW-1:0]  imm_sx;
    logic [DW-1:0]  imm_zx;
    logic [DW-1:0]  lui_val;

    alu_op_t        dec_op;
    logic [DW-1:0]  dec_b;
    logic [4:0]     dec_dest;
    logic           illegal;

    logic [DW-1:0]  alu_res;
    logic           alu_of;

    assign imem_addr = pc;

    assign opc     = f_op(ir);
    assign fn      = f_funct(ir);
    assign rs      = f_rs(ir);
    assign rt      = f_rt(ir);
    assign rd      = f_rd(ir);
    assign imm     = f_imm(ir);
    assign rs_val  = regs[rs];
    assign rt_val  = regs[rt];
    assign imm_sx  = DW'($signed(imm));
    assign imm_zx  = DW'(imm);
    // Truncation to DW leaves zero when DW=16.
    assign lui_val = DW'({imm, 16'h0000});

    always_comb begin
        illegal  = 1'b0;
        dec_op   = ALU_ADD;
        dec_b    = rt_val;
        dec_dest = rd;
        if (opc == OP_RTYPE) begin
            case (fn)
                FN_ADD:  dec_op = ALU_ADD;
                FN_SUB:  dec_op = ALU_SUB;
                FN_AND:  dec_op = ALU_AND;
                FN_OR:   dec_op = ALU_OR;
                FN_XOR:  dec_op = ALU_XOR;
                FN_NOR:  dec_op = ALU_NOR;
                FN_SLT:  dec_op = ALU_SLT;
                FN_SLL:  dec_op = ALU_SLL;
                FN_SRL:  dec_op = ALU_SRL;
                default: illegal = 1'b1;
            endcase
        end else begin
            dec_dest = rt;
            case (opc)
                OP_ADDI: begin dec_op = ALU_ADD; dec_b = imm_sx;  end
                OP_SLTI: begin dec_op = ALU_SLT; dec_b = imm_sx;  end
                OP_ANDI: begin dec_op = ALU_AND; dec_b = imm_zx;  end
                OP_ORI:  begin dec_op = ALU_OR;  dec_b = imm_zx;  end
                OP_XORI: begin dec_op = ALU_XOR; dec_b = imm_zx;  end
                OP_LUI:  begin dec_op = ALU_LUI; dec_b = lui_val; end
                default: illegal = 1'b1;
            endcase
        end
    end

    r_i_alu #(.DW(DW)) u_alu (
        .a        (op_a),
        .b        (op_b),
        .alu_op   (op_q),
        .shamt    (shamt_q),
        .result   (alu_res),
        .overflow (alu_of)
    );

    // douta/ofa double as the EXEC result registers that WB writes back.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state    <= ST_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_q     <= ALU_ADD;
            shamt_q  <= '0;
            dest_q   <= '0;
            imem_req <= 1'b0;
            douta    <= '0;
            ofa      <= 1'b0;
            zfa      <= 1'b0;
            retire   <= 1'b0;
            halted   <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (illegal) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        op_a    <= rs_val;
                        op_b    <= dec_b;
                        op_q    <= dec_op;
                        shamt_q <= f_shamt(ir);
                        dest_q  <= dec_dest;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    douta  <= alu_res;
                    ofa    <= alu_of;
                    zfa    <= (alu_res == '0);
                    retire <= 1'b1;
                    state  <= ST_WB;
                end
                ST_WB: begin
                    if ((dest_q != 5'd0) && !((OF_TRAP != 0) && ofa))
                        regs[dest_q] <= douta;
                    pc       <= pc + 1'b1;
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_r_i_cpu_mc.sv
// Directed bench for r_i_cpu_mc: one default core and one OF_TRAP=1, IAW=2
// core sharing clock and reset, each with its own instruction memory.
module tb_r_i_cpu_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_req, a_ack = 1'b0;
    logic [7:0]  a_addr;
    logic [31:0] a_data = '0;
    logic [31:0] a_dout;
    logic        a_of, a_zf, a_ret, a_halt;

    logic        b_req, b_ack = 1'b0;
    logic [1:0]  b_addr;
    logic [31:0] b_data = '0;
    logic [31:0] b_dout;
    logic        b_of, b_zf, b_ret, b_halt;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [4];
    int a_wait = 0;
    int a_cnt  = 0;
    int checks   = 0;
    int failures = 0;

    r_i_cpu_mc #(.DW(32), .IAW(8), .RESET_PC(8'd0), .OF_TRAP(0)) dut_a (
        .clka(clk), .rsta(rst), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ack(a_ack), .imem_data(a_data), .douta(a_dout), .ofa(a_of),
        .zfa(a_zf), .retire(a_ret), .halted(a_halt)
    );

    r_i_cpu_mc #(.DW(32), .IAW(2), .RESET_PC(2'd0), .OF_TRAP(1)) dut_b (
        .clka(clk), .rsta(rst), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_data(b_data), .douta(b_dout), .ofa(b_of),
        .zfa(b_zf), .retire(b_ret), .halted(b_halt)
    );

    // Memory responders: ack after a_wait request cycles (b is always zero-wait).
    always @(negedge clk) begin
        if (a_req) begin
            a_ack  = (a_cnt == a_wait);
            a_data = mem_a[a_addr];
            a_cnt  = a_cnt + 1;
        end else begin
            a_ack = 1'b0;
            a_cnt = 0;
        end
        if (b_req) begin
            b_ack  = 1'b1;
            b_data = mem_b[b_addr];
        end else begin
            b_ack = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem_a[i] = '0;
        for (int i = 0; i < 4; i++) mem_b[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] prog [15];
    logic [31:0] expv [15];
    int nret;
    int bad;

    initial begin
        // zero-wait three-instruction program, with reset values first
        clear_mem();
        mem_a[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem_a[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem_a[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req",    64'(a_req),  64'(0));
        check("rst_addr",   64'(a_addr), 64'(0));
        check("rst_dout",   64'(a_dout), 64'(0));
        check("rst_of",     64'(a_of),   64'(0));
        check("rst_zf",     64'(a_zf),   64'(0));
        check("rst_retire", 64'(a_ret),  64'(0));
        check("rst_halted", 64'(a_halt), 64'(0));
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            check($sformatf("t1_retire_c%0d", n), 64'(a_ret), 64'(n % 4 == 0));
            if (n == 1) begin
                check("t1_req_c1",  64'(a_req),  64'(1));
                check("t1_addr_c1", 64'(a_addr), 64'(0));
            end
            if (n == 2)  check("t1_req_c2", 64'(a_req), 64'(0));
            if (n == 4)  check("t1_dout_c4", 64'(a_dout), 64'h5);
            if (n == 8)  check("t1_dout_c8", 64'(a_dout), 64'hFFFF_FFFD);
            if (n == 12) begin
                check("t1_dout_c12", 64'(a_dout), 64'h2);
                check("t1_zf_c12",   64'(a_zf),   64'(0));
                check("t1_of_c12",   64'(a_of),   64'(0));
            end
        end

        // overflow: core a without trap, core b with trap and IAW=2 wrap
        clear_mem();
        mem_a[0] = enc_i(6'h0F, 5'd0, 5'd1, 16'h7FFF);
        mem_a[1] = enc_i(6'h0D, 5'd1, 5'd1, 16'hFFFF);
        mem_a[2] = enc_i(6'h08, 5'd1, 5'd2, 16'd1);
        mem_a[3] = enc_r(5'd2, 5'd0, 5'd3, 5'd0, 6'h20);
        for (int i = 0; i < 4; i++) mem_b[i] = mem_a[i];
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 4) check("t2_lui", 64'(a_dout), 64'h7FFF_0000);
            if (n == 8) begin
                check("t2_ori_a", 64'(a_dout), 64'h7FFF_FFFF);
                check("t2_ori_b", 64'(b_dout), 64'h7FFF_FFFF);
            end
            if (n == 12) begin
                check("t2_addi_dout_a", 64'(a_dout), 64'h8000_0000);
                check("t2_addi_of_a",   64'(a_of),   64'(1));
                check("t2_addi_dout_b", 64'(b_dout), 64'h8000_0000);
                check("t2_addi_of_b",   64'(b_of),   64'(1));
            end
            if (n == 13) check("t2_addr_b_c13", 64'(b_addr), 64'(3));
            if (n == 16) begin
                check("t2_add_dout_a", 64'(a_dout), 64'h8000_0000);
                check("t2_add_of_a",   64'(a_of),   64'(0));
                check("t2_add_zf_a",   64'(a_zf),   64'(0));
                check("t2_add_dout_b", 64'(b_dout), 64'(0));
                check("t2_add_zf_b",   64'(b_zf),   64'(1));
                check("t2_add_of_b",   64'(b_of),   64'(0));
            end
            if (n == 17) begin
                check("t2_wrap_addr_b", 64'(b_addr), 64'(0));
                check("t2_wrap_req_b",  64'(b_req),  64'(1));
                check("t2_addr_a_c17",  64'(a_addr), 64'(4));
            end
        end

        // three wait states on the first fetch
        clear_mem();
        mem_a[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        a_wait = 3;
        nret = 0;
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n <= 7 && a_ret) nret++;
            if (n <= 4) begin
                check($sformatf("t3_req_c%0d", n),  64'(a_req),  64'(1));
                check($sformatf("t3_addr_c%0d", n), 64'(a_addr), 64'(0));
            end
            if (n == 5) check("t3_req_drop", 64'(a_req), 64'(0));
            if (n == 6) check("t3_retire_c6", 64'(a_ret), 64'(0));
            if (n == 7) begin
                check("t3_retire_c7", 64'(a_ret),  64'(1));
                check("t3_dout_c7",   64'(a_dout), 64'h5);
            end
            if (n == 8) check("t3_next_addr", 64'(a_addr), 64'(1));
        end
        check("t3_retire_count", 64'(nret), 64'(1));
        a_wait = 0;

        // illegal instruction halts and freezes outputs
        clear_mem();
        mem_a[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
        mem_a[1] = 32'hFC00_0000;
        do_reset();
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 4) check("t4_dout_c4", 64'(a_dout), 64'h9);
            if (n == 6) check("t4_halt_c6", 64'(a_halt), 64'(0));
            if (n == 7) begin
                check("t4_halt_c7", 64'(a_halt), 64'(1));
                check("t4_req_c7",  64'(a_req),  64'(0));
            end
        end
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_req !== 1'b0 || a_dout !== 32'h9 || a_halt !== 1'b1 || a_ret !== 1'b0) bad++;
        end
        check("t4_frozen_bad_cycles", 64'(bad), 64'(0));

        // asynchronous reset during EXEC
        clear_mem();
        mem_a[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem_a[1] = enc_r(5'd1, 5'd0, 5'd2, 5'd0, 6'h20);
        do_reset();
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 4) check("t5_dout_c4", 64'(a_dout), 64'h5);
            if (n == 7) check("t5_addr_c7", 64'(a_addr), 64'(1));
        end
        rst = 1'b1;
        #1;
        check("t5_async_dout",   64'(a_dout), 64'(0));
        check("t5_async_addr",   64'(a_addr), 64'(0));
        check("t5_async_req",    64'(a_req),  64'(0));
        check("t5_async_retire", 64'(a_ret),  64'(0));
        check("t5_async_halted", 64'(a_halt), 64'(0));
        mem_a[0] = enc_r(5'd1, 5'd0, 5'd3, 5'd0, 6'h20);
        mem_a[1] = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("t5_refetch_addr", 64'(a_addr), 64'(0));
                check("t5_refetch_req",  64'(a_req),  64'(1));
            end
            if (n == 4) begin
                check("t5_reg_cleared_retire", 64'(a_ret),  64'(1));
                check("t5_reg_cleared_dout",   64'(a_dout), 64'(0));
                check("t5_reg_cleared_zf",     64'(a_zf),   64'(1));
            end
        end

        // writes to $0 are discarded but still reported
        clear_mem();
        mem_a[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        mem_a[1] = enc_r(5'd0, 5'd0, 5'd1, 5'd0, 6'h20);
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 4) begin
                check("t6_dout_c4", 64'(a_dout), 64'h7);
                check("t6_zf_c4",   64'(a_zf),   64'(0));
            end
            if (n == 8) begin
                check("t6_dout_c8", 64'(a_dout), 64'(0));
                check("t6_zf_c8",   64'(a_zf),   64'(1));
            end
        end

        // ALU sweep, one retire every four cycles
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);                expv[0]  = 32'h0000_0005;
        prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);             expv[1]  = 32'hFFFF_FFFD;
        prog[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h22);           expv[2]  = 32'h0000_0008;
        prog[3]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h24);           expv[3]  = 32'h0000_0005;
        prog[4]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h25);           expv[4]  = 32'hFFFF_FFFD;
        prog[5]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h26);           expv[5]  = 32'hFFFF_FFF8;
        prog[6]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h27);           expv[6]  = 32'h0000_0002;
        prog[7]  = enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A);           expv[7]  = 32'h0000_0001;
        prog[8]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h2A);           expv[8]  = 32'h0000_0000;
        prog[9]  = enc_i(6'h0A, 5'd2, 5'd4, 16'hFFFE);             expv[9]  = 32'h0000_0001;
        prog[10] = enc_i(6'h0C, 5'd2, 5'd4, 16'hFFFF);             expv[10] = 32'h0000_FFFD;
        prog[11] = enc_i(6'h0E, 5'd1, 5'd4, 16'h00F0);             expv[11] = 32'h0000_00F5;
        prog[12] = enc_r(5'd0, 5'd1, 5'd4, 5'd4, 6'h00);           expv[12] = 32'h0000_0050;
        prog[13] = enc_r(5'd0, 5'd2, 5'd4, 5'd28, 6'h02);          expv[13] = 32'h0000_000F;
        prog[14] = enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h20);           expv[14] = 32'h0000_0017;
        clear_mem();
        for (int k = 0; k < 15; k++) mem_a[k] = prog[k];
        do_reset();
        for (int k = 0; k < 15; k++) begin
            repeat (4) @(negedge clk);
            check($sformatf("t7_retire_%0d", k), 64'(a_ret),  64'(1));
            check($sformatf("t7_dout_%0d", k),   64'(a_dout), 64'(expv[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
